// File: rtl/npu_loader_pkg.sv
// Shared types and constants for the NPU input loader.
// Holds the loader FSM encoding and the lane geometry.
package npu_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        COLLECT = 3'd2,
        LOAD    = 3'd3,
        FIN     = 3'd4
    } state_t;

    localparam int LANES = 4;
    localparam int IDX_W = $clog2(LANES);

endpackage

// File: rtl/input_loader.sv
// Packs a byte stream into 4-lane vectors and strobes them into the NPU input buffer.
// Latency: 4 accepted bytes + 1 LOAD cycle per vector; HOLD stalls LOAD, IN_VALID bubbles stall COLLECT.
// Optional macro INPUT_LOADER_PARITY_EN adds IN_PAR input and sticky PAR_ERR output.
module input_loader
    import npu_loader_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              CLKEXT,
    input  logic              CLR_LOADER,
    input  logic              START,
    input  logic [CNT_W-1:0]  NUM_VEC,
    input  logic              IN_VALID,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              IN_READY,
    input  logic              HOLD,
`ifdef INPUT_LOADER_PARITY_EN
    input  logic              IN_PAR,
    output logic              PAR_ERR,
`endif
    output logic [DATA_W-1:0] DA,
    output logic [DATA_W-1:0] DB,
    output logic [DATA_W-1:0] DC,
    output logic [DATA_W-1:0] DD,
    output logic              EN_BUF_IN,
    output logic              CLR_BUF_IN,
    output logic              BUSY,
    output logic              DONE,
    output logic [CNT_W-1:0]  VEC_CNT
);

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   idx;
    logic [DATA_W-1:0]  lane [LANES];
    logic [CNT_W-1:0]   vec_cnt;
    logic [CNT_W-1:0]   num_vec_q;
    logic               clr_buf_q;
    logic               accept;
    logic               last_vec;

    assign accept   = (state == COLLECT) && IN_VALID;
    assign last_vec = (vec_cnt + CNT_W'(1)) == num_vec_q;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (START) begin
                    next_state = (NUM_VEC != '0) ? CLEAR : FIN;
                end
            end
            CLEAR:   next_state = COLLECT;
            COLLECT: begin
                if (accept && (idx == IDX_W'(LANES - 1))) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (!HOLD) begin
                    next_state = last_vec ? FIN : COLLECT;
                end
            end
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLKEXT) begin
        if (CLR_LOADER) begin
            state     <= IDLE;
            idx       <= '0;
            vec_cnt   <= '0;
            num_vec_q <= '0;
            clr_buf_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                lane[i] <= '0;
            end
        end else begin
            state <= next_state;
            // Buffer clear is low exactly while the FSM sits in CLEAR.
            clr_buf_q <= (next_state != CLEAR);
            case (state)
                IDLE: begin
                    if (START) begin
                        vec_cnt   <= '0;
                        num_vec_q <= NUM_VEC;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        lane[idx] <= IN_DATA;
                        idx       <= idx + IDX_W'(1);
                    end
                end
                LOAD: begin
                    if (!HOLD) begin
                        vec_cnt <= vec_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef INPUT_LOADER_PARITY_EN
    logic par_err_q;

    always_ff @(posedge CLKEXT) begin
        if (CLR_LOADER) begin
            par_err_q <= 1'b0;
        end else if ((state == IDLE) && START) begin
            par_err_q <= 1'b0;
        end else if (accept && (^{IN_DATA, IN_PAR})) begin
            par_err_q <= 1'b1;
        end
    end

    assign PAR_ERR = par_err_q;
`endif

    assign IN_READY   = (state == COLLECT);
    assign EN_BUF_IN  = (state == LOAD) && !HOLD;
    assign BUSY       = (state != IDLE);
    assign DONE       = (state == FIN);
    assign CLR_BUF_IN = clr_buf_q;
    assign VEC_CNT    = vec_cnt;
    assign DA         = lane[0];
    assign DB         = lane[1];
    assign DC         = lane[2];
    assign DD         = lane[3];

endmodule
